// File: rtl/snake_body.sv
// snake_body: per-player movement engine. Shifts the segment positions one
// cell per game tick, applying direction changes, growth and stop.
module snake_body #(
  parameter int MAX_LEN = 10,
  parameter int SEG_W = 16,
  parameter int POS_W = 10,
  parameter logic [POS_W-1:0] INIT_POS = '0,
  parameter logic [1:0] INIT_DIR = 2'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step,
  input  logic [1:0]               dir_in,
  input  logic                     dir_valid,
  input  logic                     grow,
  input  logic                     stop,
  output logic [MAX_LEN*SEG_W-1:0] snake_out,
  output logic [3:0]               length,
  output logic                     running,
  output logic                     step_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD
  } state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] body_q [MAX_LEN];
  logic [POS_W-1:0] body_d [MAX_LEN];
  logic [3:0]       len_q, len_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pdir_q, pdir_d;
  logic             grow_q, grow_d;
  logic             done_q, done_d;

  logic [4:0]       hx, hy;
  logic [4:0]       nx, ny;
  logic [POS_W-1:0] head_nxt;
  logic             rev;

  assign hx = body_q[0][4:0];
  assign hy = body_q[0][9:5];

  // 5-bit arithmetic gives the 32-cell wrap for free
  always_comb begin
    nx = hx;
    ny = hy;
    unique case (pdir_q)
      2'd0: ny = hy - 5'd1;
      2'd1: nx = hx + 5'd1;
      2'd2: ny = hy + 5'd1;
      2'd3: nx = hx - 5'd1;
    endcase
    head_nxt = '0;
    head_nxt[9:0] = {ny, nx};
  end

  assign rev = (len_q > 4'd1) && (dir_in == (dir_q ^ 2'b10));

  always_comb begin
    state_d = state_q;
    body_d  = body_q;
    len_d   = len_q;
    dir_d   = dir_q;
    pdir_d  = pdir_q;
    grow_d  = grow_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = S_RUN;
      for (int i = 0; i < MAX_LEN; i++) body_d[i] = INIT_POS;
      len_d  = 4'd1;
      dir_d  = INIT_DIR;
      pdir_d = INIT_DIR;
      grow_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (dir_valid && !rev) pdir_d = dir_in;
      if (grow) grow_d = 1'b1;
      if (stop) begin
        state_d = S_DEAD;
      end else if (step) begin
        for (int i = 1; i < MAX_LEN; i++) body_d[i] = body_q[i-1];
        body_d[0] = head_nxt;
        dir_d = pdir_q;
        if ((grow_q || grow) && (len_q < 4'(MAX_LEN)))
          len_d = len_q + 4'd1;
        grow_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= INIT_POS;
      len_q  <= 4'd1;
      dir_q  <= INIT_DIR;
      pdir_q <= INIT_DIR;
      grow_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= body_d[i];
      len_q  <= len_d;
      dir_q  <= dir_d;
      pdir_q <= pdir_d;
      grow_q <= grow_d;
      done_q <= done_d;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_out
    assign snake_out[g*SEG_W +: SEG_W] =
      {{(SEG_W-POS_W){1'b0}}, body_q[g]};
  end

  assign length    = len_q;
  assign running   = (state_q == S_RUN);
  assign step_done = done_q;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed vector table, hand sequences and a randomized run
// against a coordinate-level model of the snake.
module tb_snake_body;

  localparam int ML = 10;
  localparam int SW = 16;
  localparam int VW = ML * SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, step, dir_valid, grow, stop;
  logic [1:0]    dir_in;
  logic [VW-1:0] snake_out;
  logic [3:0]    length;
  logic          running, step_done;

  snake_body dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step      (step),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .grow      (grow),
    .stop      (stop),
    .snake_out (snake_out),
    .length    (length),
    .running   (running),
    .step_done (step_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // model: coordinates per segment, plain game rules
  int m_x [ML];
  int m_y [ML];
  int m_len, m_dir, m_pdir, m_state;
  bit m_grow, m_done;
  localparam int IDLE = 0, RUN = 1, DEAD = 2;

  task automatic model_reset();
    for (int i = 0; i < ML; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_len = 1; m_dir = 1; m_pdir = 1;
    m_grow = 0; m_done = 0; m_state = IDLE;
  endtask

  task automatic model_edge();
    int old_dir, old_pdir, nx, ny;
    m_done = 0;
    if (start) begin
      model_reset();
      m_state = RUN;
      return;
    end
    if (m_state != RUN) return;
    old_dir = m_dir;
    old_pdir = m_pdir;
    if (dir_valid && !(m_len > 1 && int'(dir_in) == (old_dir + 2) % 4))
      m_pdir = int'(dir_in);
    if (grow) m_grow = 1;
    if (stop) begin
      m_state = DEAD;
      return;
    end
    if (step) begin
      nx = m_x[0];
      ny = m_y[0];
      case (old_pdir)
        0: ny = (ny + 31) % 32;
        1: nx = (nx + 1) % 32;
        2: ny = (ny + 1) % 32;
        default: nx = (nx + 31) % 32;
      endcase
      for (int i = ML - 1; i > 0; i--) begin
        m_x[i] = m_x[i-1];
        m_y[i] = m_y[i-1];
      end
      m_x[0] = nx;
      m_y[0] = ny;
      m_dir = old_pdir;
      if (m_grow) begin
        if (m_len < ML) m_len++;
        m_grow = 0;
      end
      m_done = 1;
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < ML; i++) v[i*SW +: SW] = 16'(m_y[i] * 32 + m_x[i]);
    return v;
  endfunction

  task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic cmp_model(string tag);
    chk({tag, " body"}, snake_out, model_vec());
    chk({tag, " length"}, VW'(length), VW'(m_len));
    chk({tag, " running"}, VW'(running), VW'(m_state == RUN));
    chk({tag, " step_done"}, VW'(step_done), VW'(m_done));
  endtask

  task automatic drive(bit st, bit sp, bit dv, logic [1:0] di, bit gr, bit so);
    start = st; step = sp; dir_valid = dv;
    dir_in = di; grow = gr; stop = so;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit         st, sp, dv;
    logic [1:0] di;
    bit         gr, so;
    logic [9:0] head;
    logic [3:0] len;
    bit         run, done;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit dv, logic [1:0] di,
                              bit gr, bit so, logic [9:0] hd,
                              logic [3:0] ln, bit rn, bit dn);
    vec_t v;
    v.st = st; v.sp = sp; v.dv = dv; v.di = di; v.gr = gr; v.so = so;
    v.head = hd; v.len = ln; v.run = rn; v.done = dn;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    //            st sp dv di gr so head len run done
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 10'd0,   4'd1, 1, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 10'd1,   4'd1, 1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 10'd1,   4'd1, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 10'd2,   4'd1, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 10'd2,   4'd1, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 10'd3,   4'd1, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 10'd3,   4'd1, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 1, 0, 10'd4,   4'd2, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 10'd4,   4'd2, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 10'd5,   4'd3, 1, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 10'd6,   4'd3, 1, 1);
    tbl[11] = mk(0, 0, 1, 3, 0, 0, 10'd6,   4'd3, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 10'd7,   4'd3, 1, 1);
    tbl[13] = mk(0, 0, 1, 2, 0, 0, 10'd7,   4'd3, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 10'd39,  4'd3, 1, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 1, 10'd39,  4'd3, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 10'd39,  4'd3, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 10'd0,   4'd1, 1, 0);
    tbl[18] = mk(0, 0, 1, 3, 0, 0, 10'd0,   4'd1, 1, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 10'd31,  4'd1, 1, 1);
    tbl[20] = mk(0, 0, 1, 1, 0, 0, 10'd31,  4'd1, 1, 0);
    tbl[21] = mk(0, 1, 0, 0, 0, 0, 10'd0,   4'd1, 1, 1);
    tbl[22] = mk(0, 0, 1, 0, 0, 0, 10'd0,   4'd1, 1, 0);
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 10'd992, 4'd1, 1, 1);

    rst = 1'b1;
    drive(0, 0, 0, 2'd0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset body", snake_out, '0);
    chk("reset length", VW'(length), VW'(1));
    chk("reset running", VW'(running), '0);
    chk("reset step_done", VW'(step_done), '0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].dv, tbl[i].di, tbl[i].gr, tbl[i].so);
      cycle();
      chk($sformatf("vec%0d head", i), VW'(snake_out[9:0]), VW'(tbl[i].head));
      chk($sformatf("vec%0d length", i), VW'(length), VW'(tbl[i].len));
      chk($sformatf("vec%0d running", i), VW'(running), VW'(tbl[i].run));
      chk($sformatf("vec%0d step_done", i), VW'(step_done), VW'(tbl[i].done));
      cmp_model($sformatf("vec%0d model", i));
      drive(0, 0, 0, 2'd0, 0, 0);
    end

    // saturation: 12 grow+step from length 1
    drive(1, 0, 0, 2'd0, 0, 0);
    cycle();
    for (int k = 1; k <= 12; k++) begin
      drive(0, 1, 0, 2'd0, 1, 0);
      cycle();
      chk($sformatf("sat%0d length", k), VW'(length),
          VW'((k + 1 > ML) ? ML : k + 1));
      cmp_model($sformatf("sat%0d", k));
    end

    // asynchronous reset right after a committed step at length 4
    drive(1, 0, 0, 2'd0, 0, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 2'd2, 1, 0);
      cycle();
    end
    drive(0, 1, 0, 2'd0, 0, 0);
    cycle();
    chk("pre-rst length", VW'(length), VW'(4));
    chk("pre-rst step_done", VW'(step_done), VW'(1));
    rst = 1'b1;
    drive(0, 0, 0, 2'd0, 0, 0);
    #1;
    chk("async rst body", snake_out, '0);
    chk("async rst length", VW'(length), VW'(1));
    chk("async rst running", VW'(running), '0);
    chk("async rst step_done", VW'(step_done), '0);
    model_reset();
    #2;
    rst = 1'b0;
    drive(0, 1, 0, 2'd0, 0, 0);
    cycle();
    cmp_model("post-rst idle step");

    // randomized play against the model
    drive(1, 0, 0, 2'd0, 0, 0);
    cycle();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(99) < 3, $urandom_range(99) < 55,
            $urandom_range(99) < 35, 2'($urandom_range(3)),
            $urandom_range(99) < 20, $urandom_range(99) < 3);
      cycle();
      cmp_model($sformatf("rand%0d", n));
    end
    drive(0, 0, 0, 2'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
